// File: rtl/jk_bank_sequencer.sv
// Command sequencer for a bank of negedge JK flip-flops: loads, clears, toggles
// or counts the bank modulo MODULUS by driving per-bit J/K, reading Q back via iQ.
module jk_bank_sequencer #(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 10
) (
    input  logic             iClk,
    input  logic             iReset_n,
    input  logic             iCmdValid,
    output logic             oCmdReady,
    input  logic [2:0]       iCmdOp,
    input  logic [WIDTH-1:0] iCmdData,
    input  logic [WIDTH-1:0] iQ,
    output logic [WIDTH-1:0] oJ,
    output logic [WIDTH-1:0] oK,
    output logic             oBusy,
    output logic             oDone,
    output logic             oWrap
);
    typedef enum logic [1:0] {IDLE, APPLY, STEP, DONE} state_t;

    localparam logic [2:0] OP_CLEAR  = 3'b001;
    localparam logic [2:0] OP_LOAD   = 3'b010;
    localparam logic [2:0] OP_CNT_UP = 3'b011;
    localparam logic [2:0] OP_CNT_DN = 3'b100;
    localparam logic [2:0] OP_TOGGLE = 3'b101;

    // One extra bit so MODULUS == 2**WIDTH still compares correctly.
    localparam logic [WIDTH:0]   MOD_X    = (WIDTH+1)'(MODULUS);
    localparam logic [WIDTH:0]   MOD_M1_X = (WIDTH+1)'(MODULUS - 1);
    localparam logic [WIDTH-1:0] TOP      = WIDTH'(MODULUS - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] j_q, j_d, k_q, k_d, rem_q, rem_d, rem_dec;
    logic             up_q, up_d, wrap_q, wrap_d, done_q, done_d;
    logic             busy_q, busy_d, ready_q, ready_d;
    logic             step_up, step_w;
    logic [WIDTH-1:0] step_t;

    // Direction comes from the incoming op at accept, from the latched op afterwards.
    assign step_up = (state_q == IDLE) ? (iCmdOp == OP_CNT_UP) : up_q;
    assign rem_dec = rem_q - 1'b1;

    always_comb begin
        step_w = 1'b0;
        step_t = '0;
        if (step_up) begin
            if ({1'b0, iQ} >= MOD_M1_X) begin
                step_w = 1'b1;
            end else begin
                step_t = iQ + 1'b1;
            end
        end else begin
            if (iQ == '0 || {1'b0, iQ} >= MOD_X) begin
                step_w = 1'b1;
                step_t = TOP;
            end else begin
                step_t = iQ - 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        j_d     = '0;
        k_d     = '0;
        wrap_d  = 1'b0;
        rem_d   = rem_q;
        up_d    = up_q;
        case (state_q)
            IDLE: begin
                if (iCmdValid && ready_q) begin
                    case (iCmdOp)
                        OP_CLEAR: begin
                            k_d     = '1;
                            state_d = APPLY;
                        end
                        OP_LOAD: begin
                            j_d     = iCmdData;
                            k_d     = ~iCmdData;
                            state_d = APPLY;
                        end
                        OP_TOGGLE: begin
                            j_d     = '1;
                            k_d     = '1;
                            state_d = APPLY;
                        end
                        OP_CNT_UP, OP_CNT_DN: begin
                            up_d = (iCmdOp == OP_CNT_UP);
                            if (iCmdData == '0) begin
                                state_d = DONE;
                            end else begin
                                rem_d   = iCmdData;
                                j_d     = step_t;
                                k_d     = ~step_t;
                                wrap_d  = step_w;
                                state_d = STEP;
                            end
                        end
                        default: state_d = DONE;
                    endcase
                end
            end
            APPLY: state_d = DONE;
            STEP: begin
                rem_d = rem_dec;
                if (rem_dec != '0) begin
                    j_d    = step_t;
                    k_d    = ~step_t;
                    wrap_d = step_w;
                end else begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        ready_d = (state_d == IDLE);
        busy_d  = (state_d != IDLE);
        done_d  = (state_d == DONE);
    end

    always_ff @(posedge iClk or negedge iReset_n) begin
        if (!iReset_n) begin
            state_q <= IDLE;
            j_q     <= '0;
            k_q     <= '0;
            rem_q   <= '0;
            up_q    <= 1'b0;
            wrap_q  <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            j_q     <= j_d;
            k_q     <= k_d;
            rem_q   <= rem_d;
            up_q    <= up_d;
            wrap_q  <= wrap_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            ready_q <= ready_d;
        end
    end

    assign oJ        = j_q;
    assign oK        = k_q;
    assign oWrap     = wrap_q;
    assign oDone     = done_q;
    assign oBusy     = busy_q;
    assign oCmdReady = ready_q;
endmodule

// File: tb/tb_jk_bank_sequencer.sv
// Bench for jk_bank_sequencer driving a behavioural 4-bit negedge JK bank;
// results are compared against an integer model of the command semantics.
module tb_jk_bank_sequencer;
    localparam int W = 4;
    localparam int M = 10;

    logic         iClk = 1'b0;
    logic         iReset_n, bank_rst_n, iCmdValid, oCmdReady;
    logic [2:0]   iCmdOp;
    logic [W-1:0] iCmdData, iQ, oJ, oK, bank_q;
    logic         oBusy, oDone, oWrap;

    int vectors = 0;
    int miscompares = 0;
    int mq = 0;

    always #5 iClk = ~iClk;

    // JK bank with its own reset: 00 hold, 10 set, 01 clear, 11 toggle.
    always @(negedge iClk or negedge bank_rst_n) begin
        if (!bank_rst_n) bank_q <= '0;
        else bank_q <= (bank_q & ~oJ & ~oK) | (oJ & ~oK) | (~bank_q & oJ & oK);
    end
    assign iQ = bank_q;

    jk_bank_sequencer #(.WIDTH(W), .MODULUS(M)) dut (
        .iClk(iClk), .iReset_n(iReset_n), .iCmdValid(iCmdValid), .oCmdReady(oCmdReady),
        .iCmdOp(iCmdOp), .iCmdData(iCmdData), .iQ(iQ), .oJ(oJ), .oK(oK),
        .oBusy(oBusy), .oDone(oDone), .oWrap(oWrap)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int step_model(input bit up, input int q, output bit w);
        if (up) begin
            w = (q >= M - 1);
            return w ? 0 : q + 1;
        end
        w = (q == 0 || q >= M);
        return w ? M - 1 : q - 1;
    endfunction

    // Issue one command, watch it to completion and compare with the model.
    task automatic run_cmd(input logic [2:0] op, input logic [W-1:0] data);
        int exp_q[16];
        int qtr[40];
        int exp_mask, exp_busy, exp_jk, nsteps, busy_c, done_c, jk_c, wmask, waitc;
        bit w, seen;
        exp_mask = 0; busy_c = 0; done_c = 0; jk_c = 0; wmask = 0; nsteps = 0; waitc = 0;
        exp_busy = 1; exp_jk = 0;
        case (op)
            3'd1: begin mq = 0;          exp_busy = 2; exp_jk = 1; end
            3'd2: begin mq = int'(data); exp_busy = 2; exp_jk = 1; end
            3'd5: begin mq = 15 - mq;    exp_busy = 2; exp_jk = 1; end
            3'd3, 3'd4: begin
                nsteps = int'(data);
                for (int i = 0; i < nsteps; i++) begin
                    mq = step_model(op == 3'd3, mq, w);
                    exp_q[i] = mq;
                    if (w) exp_mask |= (1 << i);
                end
                exp_busy = nsteps + 1;
                exp_jk   = nsteps;
            end
            default: ;
        endcase

        while (!oCmdReady && waitc < 20) begin
            @(posedge iClk); #1;
            waitc++;
        end
        chk("ready_before", 32'(oCmdReady), 1);
        iCmdValid = 1'b1; iCmdOp = op; iCmdData = data;
        @(posedge iClk); #1;
        iCmdValid = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (oBusy) busy_c++;
            if (oDone) done_c++;
            if ((oJ | oK) != '0) jk_c++;
            if (oWrap) wmask |= (1 << c);
            seen = oDone;
            @(negedge iClk); #1;
            qtr[c] = int'(iQ);
            @(posedge iClk); #1;
            if (seen) break;
        end
        for (int i = 0; i < nsteps; i++) chk("step_q", 32'(qtr[i]), 32'(exp_q[i]));
        chk("busy_cycles", 32'(busy_c), 32'(exp_busy));
        chk("done_pulses", 32'(done_c), 1);
        chk("jk_drive_cycles", 32'(jk_c), 32'(exp_jk));
        chk("wrap_mask", 32'(wmask), 32'(exp_mask));
        chk("final_q", 32'(iQ), 32'(mq));
        chk("ready_after", 32'(oCmdReady), 1);
        chk("busy_after", 32'(oBusy), 0);
    endtask

    initial begin
        int c, done_c, exp_after;
        bit w;
        iReset_n = 1'b0; bank_rst_n = 1'b0; iCmdValid = 1'b0; iCmdOp = '0; iCmdData = '0;
        repeat (2) @(posedge iClk);
        #1;
        chk("rst_j", 32'(oJ), 0);
        chk("rst_k", 32'(oK), 0);
        chk("rst_busy", 32'(oBusy), 0);
        chk("rst_done", 32'(oDone), 0);
        chk("rst_wrap", 32'(oWrap), 0);
        chk("rst_ready", 32'(oCmdReady), 1);
        iReset_n = 1'b1; bank_rst_n = 1'b1;
        @(posedge iClk); #1;

        run_cmd(3'd2, 4'd7);            // LOAD 7
        run_cmd(3'd3, 4'd5);            // UP 5: 8,9,0,1,2
        run_cmd(3'd2, 4'd1);
        run_cmd(3'd4, 4'd3);            // DN 3: 0,9,8
        run_cmd(3'd2, 4'd12);
        run_cmd(3'd3, 4'd1);            // 12 -> 0 with wrap
        run_cmd(3'd2, 4'd10);
        run_cmd(3'd1, 4'd0);            // CLEAR
        run_cmd(3'd2, 4'd5);
        run_cmd(3'd5, 4'd0);            // TOGGLE 0101 -> 1010
        run_cmd(3'd0, 4'd9);            // NOP
        run_cmd(3'd7, 4'd3);            // illegal
        run_cmd(3'd6, 4'd3);            // illegal
        run_cmd(3'd3, 4'd0);            // UP N=0
        run_cmd(3'd4, 4'd0);            // DN N=0

        // Command held valid through a busy count: taken only once idle again.
        exp_after = mq;
        for (int i = 0; i < 3; i++) exp_after = step_model(1'b1, exp_after, w);
        iCmdValid = 1'b1; iCmdOp = 3'd3; iCmdData = 4'd3;
        @(posedge iClk); #1;
        iCmdOp = 3'd2; iCmdData = 4'd5;
        c = 0;
        while (!oCmdReady && c < 20) begin
            @(posedge iClk); #1;
            c++;
        end
        chk("held_wait", 32'(c), 4);
        chk("held_q_before_load", 32'(iQ), 32'(exp_after));
        @(posedge iClk); #1;
        iCmdValid = 1'b0;
        @(posedge iClk); #1;
        chk("held_load_q", 32'(iQ), 5);
        @(posedge iClk); #1;
        chk("held_ready", 32'(oCmdReady), 1);
        mq = 5;

        for (int n = 0; n < 40; n++)
            run_cmd(3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)));

        // Reset in the middle of UP 8: two steps land before the reset.
        run_cmd(3'd2, 4'd3);
        exp_after = mq;
        for (int i = 0; i < 2; i++) exp_after = step_model(1'b1, exp_after, w);
        iCmdValid = 1'b1; iCmdOp = 3'd3; iCmdData = 4'd8;
        @(posedge iClk); #1;
        iCmdValid = 1'b0;
        repeat (2) begin @(posedge iClk); #1; end
        #1 iReset_n = 1'b0;
        #1;
        chk("abort_j", 32'(oJ), 0);
        chk("abort_k", 32'(oK), 0);
        chk("abort_busy", 32'(oBusy), 0);
        chk("abort_wrap", 32'(oWrap), 0);
        done_c = 0;
        repeat (3) begin @(posedge iClk); #1; if (oDone) done_c++; end
        iReset_n = 1'b1;
        repeat (3) begin @(posedge iClk); #1; if (oDone) done_c++; end
        chk("abort_no_done", 32'(done_c), 0);
        chk("abort_ready", 32'(oCmdReady), 1);
        chk("abort_q_hold", 32'(iQ), 32'(exp_after));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
